// File: rtl/ccu_snoop_responder.sv
// ccu_snoop_responder: cache-side ACE snoop responder (AC in, cache lookup, CR response, CD line beats)
// Ports:
//   clk_i, rst_ni                      clock, asynchronous active-low reset
//   ac_valid_i/ac_ready_o/ac_addr_i/ac_snoop_i   snoop request channel
//   cr_valid_o/cr_ready_i/cr_resp_o    snoop response channel
//   cd_valid_o/cd_ready_i/cd_data_o/cd_last_o    snoop data channel, lowest beat first
//   lu_valid_o/lu_ready_i/lu_addr_o/lu_inval_o   data cache lookup request
//   lu_rvalid_i/lu_hit_i/lu_dirty_i/lu_shared_i/lu_data_i   lookup result
module ccu_snoop_responder #(
    parameter int unsigned DcacheLineWidth = 128,
    parameter int unsigned AxiDataWidth    = 64,
    parameter int unsigned AxiAddrWidth    = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       ac_valid_i,
    output logic                       ac_ready_o,
    input  logic [AxiAddrWidth-1:0]    ac_addr_i,
    input  logic [3:0]                 ac_snoop_i,
    output logic                       cr_valid_o,
    input  logic                       cr_ready_i,
    output logic [4:0]                 cr_resp_o,
    output logic                       cd_valid_o,
    input  logic                       cd_ready_i,
    output logic [AxiDataWidth-1:0]    cd_data_o,
    output logic                       cd_last_o,
    output logic                       lu_valid_o,
    input  logic                       lu_ready_i,
    output logic [AxiAddrWidth-1:0]    lu_addr_o,
    output logic                       lu_inval_o,
    input  logic                       lu_rvalid_i,
    input  logic                       lu_hit_i,
    input  logic                       lu_dirty_i,
    input  logic                       lu_shared_i,
    input  logic [DcacheLineWidth-1:0] lu_data_i
);
    localparam int unsigned Words   = DcacheLineWidth / AxiDataWidth;
    localparam int unsigned OffBits = $clog2(DcacheLineWidth / 8);
    localparam int unsigned CntW    = $clog2(Words);
    localparam logic [AxiAddrWidth-1:0] OffMask = {{(AxiAddrWidth-OffBits){1'b0}}, {OffBits{1'b1}}};

    typedef enum logic [2:0] {IDLE, LOOKUP, WAIT_RESULT, SEND_CR, SEND_CD} state_t;

    state_t                     state_q;
    logic [AxiAddrWidth-1:0]    addr_q;
    logic [3:0]                 snoop_q;
    logic [4:0]                 resp_q;
    logic [DcacheLineWidth-1:0] line_q;
    logic [CntW-1:0]            cnt_q;
    logic                       op_read, op_data, op_inval, op_legal, last_beat, xfer;

    assign op_read   = snoop_q == 4'b0000 || snoop_q == 4'b0001;
    assign op_data   = op_read || snoop_q == 4'b0111 || snoop_q == 4'b1001;
    assign op_inval  = snoop_q == 4'b0111 || snoop_q == 4'b1001 || snoop_q == 4'b1101;
    assign op_legal  = op_data || snoop_q == 4'b1101;
    assign last_beat = cnt_q == CntW'(Words - 1);
    assign xfer      = lu_hit_i & op_data;

    assign ac_ready_o = state_q == IDLE;
    assign lu_valid_o = state_q == LOOKUP;
    assign cr_valid_o = state_q == SEND_CR;
    assign cd_valid_o = state_q == SEND_CD;
    assign lu_addr_o  = lu_valid_o ? addr_q & ~OffMask : '0;
    assign lu_inval_o = lu_valid_o & op_inval;
    assign cr_resp_o  = cr_valid_o ? resp_q : '0;
    assign cd_data_o  = cd_valid_o ? line_q[cnt_q*AxiDataWidth +: AxiDataWidth] : '0;
    assign cd_last_o  = cd_valid_o & last_beat;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            addr_q  <= '0;
            snoop_q <= '0;
            resp_q  <= '0;
            line_q  <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (ac_valid_i) begin
                    addr_q  <= ac_addr_i;
                    snoop_q <= ac_snoop_i;
                    state_q <= LOOKUP;
                end
                LOOKUP: if (lu_ready_i) state_q <= WAIT_RESULT;
                WAIT_RESULT: if (lu_rvalid_i) begin
                    line_q  <= lu_data_i;
                    // {WasUnique, IsShared, PassDirty, Error, DataTransfer}; illegal codes report Error only
                    resp_q  <= {lu_hit_i & ~lu_shared_i & op_legal, lu_hit_i & op_read,
                                xfer & lu_dirty_i & (snoop_q != 4'b0000), ~op_legal, xfer};
                    state_q <= SEND_CR;
                end
                SEND_CR: if (cr_ready_i) state_q <= resp_q[0] ? SEND_CD : IDLE;
                SEND_CD: if (cd_ready_i) begin
                    cnt_q   <= last_beat ? '0 : cnt_q + 1'b1;
                    state_q <= last_beat ? IDLE : SEND_CD;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
